elevator_door_controller: RTL and testbench

- Downstream stage of each car's floor-scheduling core; one instance per car.
- Consumes the car's arrival pulse (`complete`), `over_weight` and `out_floor`, and sequences the door through open, dwell and close.
- Drives `car_hold` back to the scheduling core so the car cannot leave while the door is not fully closed; reports door state and an overload buzzer.

---
 rtl/elevator_door_controller.sv | 146 ++++++++++++++
 tb/tb_elevator_door_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_door_controller.sv
// elevator_door_controller: per-car door sequencer (open, dwell, close) with reopen/nudge and overload hold
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   complete                           arrival level from scheduler (rising edge used)
//   over_weight, out_floor, direction  car status from scheduler
//   door_obstruct, door_open_btn,
//   door_close_btn                     synchronised door sensors / in-car buttons
//   door_open, door_close              motor drives
//   door_state                         0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING, 4 HOLD_OW
//   car_hold                           car must not move
//   buzzer                             overload / nudge alert
//   open_floor                         floor latched at last door opening
//   cycle_count                        completed open/close cycles, saturating
module elevator_door_controller #(
    parameter int OPEN_TIME  = 8,
    parameter int DWELL_TIME = 16,
    parameter int CLOSE_TIME = 8,
    parameter int MAX_REOPEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       complete,
    input  logic       over_weight,
    input  logic [2:0] out_floor,
    input  logic [1:0] direction,
    input  logic       door_obstruct,
    input  logic       door_open_btn,
    input  logic       door_close_btn,
    output logic       door_open,
    output logic       door_close,
    output logic [2:0] door_state,
    output logic       car_hold,
    output logic       buzzer,
    output logic [2:0] open_floor,
    output logic [7:0] cycle_count
);
    localparam int MAXT = (OPEN_TIME > DWELL_TIME) ? ((OPEN_TIME > CLOSE_TIME) ? OPEN_TIME : CLOSE_TIME)
                                                   : ((DWELL_TIME > CLOSE_TIME) ? DWELL_TIME : CLOSE_TIME);
    localparam int TW = $clog2(MAXT + 1);
    localparam int RW = $clog2(MAX_REOPEN + 2);
    localparam logic [TW-1:0] OT = TW'(OPEN_TIME);
    localparam logic [TW-1:0] DT = TW'(DWELL_TIME);
    localparam logic [TW-1:0] CT = TW'(CLOSE_TIME);
    localparam logic [TW-1:0] T1 = TW'(1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_REOPEN);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        HOLD_OW = 3'd4
    } state_t;

    state_t state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [RW-1:0] reopen_cnt, reopen_nx;
    logic [2:0] open_floor_nx;
    logic [7:0] cycle_nx;
    logic complete_q, armed, arrive, nudge;

    // armed stays low for the first edge after reset so a level-high complete is not an arrival
    assign arrive = complete & ~complete_q & armed;
    assign nudge  = (reopen_cnt == RMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLOSED;
            timer       <= '0;
            reopen_cnt  <= '0;
            complete_q  <= 1'b0;
            armed       <= 1'b0;
            open_floor  <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            reopen_cnt  <= reopen_nx;
            complete_q  <= complete;
            armed       <= 1'b1;
            open_floor  <= open_floor_nx;
            cycle_count <= cycle_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        reopen_nx     = reopen_cnt;
        open_floor_nx = open_floor;
        cycle_nx      = cycle_count;
        case (state)
            CLOSED:
                if (arrive || (door_open_btn && direction == 2'd0)) begin
                    state_nx      = OPENING;
                    timer_nx      = OT;
                    open_floor_nx = out_floor;
                end
            OPENING:
                if (timer == T1) begin
                    state_nx = OPEN;
                    timer_nx = DT;
                end else begin
                    timer_nx = timer - T1;
                end
            OPEN:
                if (over_weight) begin
                    state_nx = HOLD_OW;
                end else if (door_obstruct || door_open_btn) begin
                    timer_nx = DT;
                end else if (door_close_btn || timer == T1) begin
                    state_nx = CLOSING;
                    timer_nx = CT;
                end else begin
                    timer_nx = timer - T1;
                end
            HOLD_OW:
                if (!over_weight) begin
                    state_nx = OPEN;
                    timer_nx = DT;
                end
            CLOSING:
                // in nudge mode only the obstruction sensor can reopen, and the count holds
                if (door_obstruct || (door_open_btn && !nudge)) begin
                    state_nx  = OPENING;
                    timer_nx  = OT;
                    reopen_nx = nudge ? reopen_cnt : reopen_cnt + RW'(1);
                end else if (timer == T1) begin
                    state_nx  = CLOSED;
                    timer_nx  = '0;
                    reopen_nx = '0;
                    cycle_nx  = (cycle_count == 8'hFF) ? cycle_count : cycle_count + 8'd1;
                end else begin
                    timer_nx = timer - T1;
                end
            default:
                state_nx = CLOSED;
        endcase
    end

    assign door_state = state;
    assign door_open  = (state == OPENING);
    assign door_close = (state == CLOSING);
    assign car_hold   = (state != CLOSED);
    assign buzzer     = (state == HOLD_OW) || (state == CLOSING && nudge);
endmodule

// File: tb/tb_elevator_door_controller.sv
// tb_elevator_door_controller: directed self-checking bench for elevator_door_controller
module tb_elevator_door_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       complete, over_weight, door_obstruct, door_open_btn, door_close_btn;
    logic [2:0] out_floor;
    logic [1:0] direction;
    logic       door_open, door_close, car_hold, buzzer;
    logic [2:0] door_state, open_floor;
    logic [7:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int hold_cnt = 0;

    elevator_door_controller dut (
        .clk(clk), .rst_n(rst_n), .complete(complete), .over_weight(over_weight),
        .out_floor(out_floor), .direction(direction), .door_obstruct(door_obstruct),
        .door_open_btn(door_open_btn), .door_close_btn(door_close_btn),
        .door_open(door_open), .door_close(door_close), .door_state(door_state),
        .car_hold(car_hold), .buzzer(buzzer), .open_floor(open_floor), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // counts consecutive sampled cycles spent in state s (bounded)
    task automatic dur(input logic [2:0] s, output int n);
        n = 0;
        while (door_state == s && n < 200) begin
            n++;
            if (car_hold) hold_cnt++;
            step();
        end
    endtask

    task automatic arrive_car(input logic [2:0] f);
        out_floor = f;
        complete = 1'b0;
        step();
        complete = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; complete = 0; over_weight = 0; door_obstruct = 0;
        door_open_btn = 0; door_close_btn = 0; out_floor = 0; direction = 2'd1;
        step(); step();
        checks++;
        if ({door_open, door_close, car_hold, buzzer, door_state, open_floor, cycle_count} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {door_open, door_close, car_hold, buzzer, door_state, open_floor, cycle_count});
        end
        rst_n = 1'b1;
        step(); step();
    endtask

    task automatic test_basic_cycle();
        int n;
        hold_cnt = 0;
        arrive_car(3'd3);
        checks++;
        if (door_state !== 3'd1 || car_hold !== 1'b1 || door_open !== 1'b1 || door_close !== 1'b0) begin
            errors++;
            $display("FAIL arrival_latency: state=%0d hold=%b open=%b close=%b required 1 1 1 0", door_state, car_hold, door_open, door_close);
        end
        dur(3'd1, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL opening_len: got %0d required 8", n); end
        dur(3'd2, n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL dwell_len: got %0d required 16", n); end
        checks++;
        if (door_close !== 1'b1 || door_open !== 1'b0) begin errors++; $display("FAIL closing_motor: open=%b close=%b required 0 1", door_open, door_close); end
        dur(3'd3, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL closing_len: got %0d required 8", n); end
        checks++;
        if (door_state !== 3'd0 || car_hold !== 1'b0 || open_floor !== 3'd3 || cycle_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_end: state=%0d hold=%b floor=%0d count=%0d required 0 0 3 1", door_state, car_hold, open_floor, cycle_count);
        end
        checks++;
        if (hold_cnt !== 32) begin errors++; $display("FAIL hold_len: got %0d required 32", hold_cnt); end
    endtask

    task automatic test_open_btn_hold();
        int n, bad;
        arrive_car(3'd5);
        dur(3'd1, n);
        door_open_btn = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (door_state !== 3'd2) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL open_btn_hold: %0d non-OPEN cycles required 0", bad); end
        door_open_btn = 1'b0;
        dur(3'd2, n);
        checks++;
        if (n !== 16 || door_state !== 3'd3) begin errors++; $display("FAIL open_btn_release: dwell=%0d state=%0d required 16 3", n, door_state); end
        dur(3'd3, n);
        checks++;
        if (open_floor !== 3'd5) begin errors++; $display("FAIL open_floor_latch: got %0d required 5", open_floor); end
    endtask

    task automatic test_reopen_nudge();
        int n;
        arrive_car(3'd2);
        dur(3'd1, n);
        dur(3'd2, n);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (door_state !== 3'd3 || buzzer !== 1'b0) begin errors++; $display("FAIL reopen_pre_%0d: state=%0d buzzer=%b required 3 0", i, door_state, buzzer); end
            door_obstruct = 1'b1;
            step();
            door_obstruct = 1'b0;
            checks++;
            if (door_state !== 3'd1) begin errors++; $display("FAIL reopen_%0d: state=%0d required 1", i, door_state); end
            dur(3'd1, n);
            dur(3'd2, n);
        end
        checks++;
        if (door_state !== 3'd3 || buzzer !== 1'b1) begin errors++; $display("FAIL nudge_buzzer: state=%0d buzzer=%b required 3 1", door_state, buzzer); end
        door_obstruct = 1'b1;
        step();
        door_obstruct = 1'b0;
        checks++;
        if (door_state !== 3'd1) begin errors++; $display("FAIL nudge_obstruct: state=%0d required 1", door_state); end
        dur(3'd1, n);
        dur(3'd2, n);
        checks++;
        if (buzzer !== 1'b1) begin errors++; $display("FAIL nudge_buzzer_held: got %b required 1", buzzer); end
        door_open_btn = 1'b1;
        step();
        door_open_btn = 1'b0;
        checks++;
        if (door_state !== 3'd3) begin errors++; $display("FAIL nudge_btn_ignored: state=%0d required 3", door_state); end
        dur(3'd3, n);
        checks++;
        if (door_state !== 3'd0 || buzzer !== 1'b0 || cycle_count !== 8'd3) begin
            errors++;
            $display("FAIL nudge_close: state=%0d buzzer=%b count=%0d required 0 0 3", door_state, buzzer, cycle_count);
        end
    endtask

    task automatic test_overweight();
        int n, bad;
        arrive_car(3'd1);
        dur(3'd1, n);
        over_weight = 1'b1;
        step();
        checks++;
        if (door_state !== 3'd4 || buzzer !== 1'b1 || car_hold !== 1'b1 || door_open !== 1'b0 || door_close !== 1'b0) begin
            errors++;
            $display("FAIL hold_ow_enter: state=%0d buzzer=%b hold=%b open=%b close=%b required 4 1 1 0 0", door_state, buzzer, car_hold, door_open, door_close);
        end
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (door_state !== 3'd4 || buzzer !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hold_ow_stay: %0d bad cycles required 0", bad); end
        over_weight = 1'b0;
        step();
        dur(3'd2, n);
        checks++;
        if (n !== 16 || door_state !== 3'd3 || buzzer !== 1'b0) begin errors++; $display("FAIL ow_release_dwell: dwell=%0d state=%0d buzzer=%b required 16 3 0", n, door_state, buzzer); end
        dur(3'd3, n);
        checks++;
        if (cycle_count !== 8'd4) begin errors++; $display("FAIL ow_count: got %0d required 4", cycle_count); end
    endtask

    task automatic test_close_btn();
        int n, bad;
        arrive_car(3'd6);
        dur(3'd1, n);
        step();
        door_close_btn = 1'b1;
        step();
        door_close_btn = 1'b0;
        checks++;
        if (door_state !== 3'd3) begin errors++; $display("FAIL close_btn: state=%0d required 3", door_state); end
        dur(3'd3, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL close_btn_closing: got %0d required 8", n); end
        arrive_car(3'd6);
        dur(3'd1, n);
        door_close_btn = 1'b1;
        door_obstruct = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (door_state !== 3'd2) bad++;
        end
        door_close_btn = 1'b0;
        door_obstruct = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL close_vs_obstruct: %0d non-OPEN cycles required 0", bad); end
        dur(3'd2, n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL close_vs_obstruct_dwell: got %0d required 16", n); end
        dur(3'd3, n);
        checks++;
        if (cycle_count !== 8'd6) begin errors++; $display("FAIL close_count: got %0d required 6", cycle_count); end
    endtask

    task automatic test_async_reset();
        int n, bad;
        arrive_car(3'd4);
        dur(3'd1, n);
        dur(3'd2, n);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({door_open, door_close, car_hold, buzzer, door_state, open_floor, cycle_count} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {door_open, door_close, car_hold, buzzer, door_state, open_floor, cycle_count});
        end
        complete = 1'b1;
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (door_state !== 3'd0 || car_hold !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL no_arrival_after_reset: %0d bad cycles required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_open_btn_hold();
        test_reopen_nudge();
        test_overweight();
        test_close_btn();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
